// File: rtl/cpu7_icu_fetch_bridge.sv
// cpu7_icu_fetch_bridge: instruction fetch bridge between the IFU and instruction memory, with pipelined reads and cancel-drop
module cpu7_icu_fetch_bridge #(
    parameter int MAX_OUTST = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ifu_icu_req_ic1,
    input  logic [31:0] ifu_icu_addr_ic1,
    output logic        icu_ifu_ack_ic1,
    input  logic        ifu_icu_cancel,
    output logic [63:0] icu_ifu_data_ic2,
    output logic        icu_ifu_data_valid_ic2,
    output logic        icu_ifu_err_ic2,
    output logic        icu_mem_req,
    output logic [31:0] icu_mem_addr,
    input  logic        mem_icu_ack,
    input  logic        mem_icu_rvalid,
    input  logic [63:0] mem_icu_rdata,
    input  logic        mem_icu_rerr
);
    logic [2:0]  outst_q, outst_d, drop_q, drop_d;
    logic        data_vld_q, err_q, issue, resp, fwd;
    logic [63:0] data_q;

    assign resp                   = mem_icu_rvalid;
    assign icu_mem_req            = ifu_icu_req_ic1 & (outst_q < 3'(MAX_OUTST)) & ~ifu_icu_cancel;
    assign icu_ifu_ack_ic1        = icu_mem_req & mem_icu_ack;
    assign issue                  = icu_ifu_ack_ic1;
    assign icu_mem_addr           = ifu_icu_addr_ic1 & ~32'h7;
    assign fwd                    = resp & ~ifu_icu_cancel & (drop_q == 3'd0);
    assign icu_ifu_data_valid_ic2 = data_vld_q & ~ifu_icu_cancel;
    assign icu_ifu_data_ic2       = data_q;
    assign icu_ifu_err_ic2        = err_q;

    // Outstanding count tracks issue minus response; a cancel marks every still-pending read for dropping.
    always_comb begin
        outst_d = outst_q + {2'b00, issue} - {2'b00, resp};
        drop_d  = ifu_icu_cancel ? outst_q - {2'b00, resp}
                : (resp && drop_q != 3'd0) ? drop_q - 3'd1
                : drop_q;
    end

    // State registers; forwarded responses are captured for a one-cycle valid pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            outst_q    <= 3'd0;
            drop_q     <= 3'd0;
            data_vld_q <= 1'b0;
            data_q     <= 64'd0;
            err_q      <= 1'b0;
        end else begin
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            data_vld_q <= fwd;
            if (fwd) begin
                data_q <= mem_icu_rdata;
                err_q  <= mem_icu_rerr;
            end
        end
    end
endmodule
